// File: rtl/scpad_dram_arbiter_if.sv
// Bundle of backend-facing and DRAM-facing signals around the scratchpad
// DRAM arbiter. The arbiter uses the master view; the surrounding
// backends and DRAM model use the slave view.
interface scpad_dram_arbiter_if #(
  parameter int NUM_BE = 2,
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int LANES  = 4,
  parameter int LANE_W = 16
);
  localparam int DATA_W = LANES * LANE_W;

  logic [NUM_BE-1:0]        be_req_valid;
  logic [NUM_BE-1:0]        be_req_write;
  logic [NUM_BE*ID_W-1:0]   be_req_id;
  logic [NUM_BE*ADDR_W-1:0] be_req_addr;
  logic [NUM_BE*LANES-1:0]  be_req_mask;
  logic [NUM_BE*DATA_W-1:0] be_req_wdata;
  logic [NUM_BE-1:0]        be_res_stall;
  logic [NUM_BE-1:0]        dram_be_stall;
  logic [NUM_BE-1:0]        dram_be_res_valid;
  logic [NUM_BE*ID_W-1:0]   dram_be_res_id;
  logic [NUM_BE*DATA_W-1:0] dram_be_res_rdata;

  logic                     dram_req_valid;
  logic                     dram_req_ready;
  logic                     dram_req_write;
  logic [ID_W-1:0]          dram_req_id;
  logic [ADDR_W-1:0]        dram_req_addr;
  logic [LANES-1:0]         dram_req_mask;
  logic [DATA_W-1:0]        dram_req_wdata;
  logic                     dram_res_valid;
  logic                     dram_res_ready;
  logic [ID_W-1:0]          dram_res_id;
  logic [DATA_W-1:0]        dram_res_rdata;
  logic                     err_orphan;

  modport master (
    input  be_req_valid, be_req_write, be_req_id, be_req_addr, be_req_mask,
           be_req_wdata, be_res_stall, dram_req_ready, dram_res_valid,
           dram_res_id, dram_res_rdata,
    output dram_be_stall, dram_be_res_valid, dram_be_res_id, dram_be_res_rdata,
           dram_req_valid, dram_req_write, dram_req_id, dram_req_addr,
           dram_req_mask, dram_req_wdata, dram_res_ready, err_orphan
  );

  modport slave (
    output be_req_valid, be_req_write, be_req_id, be_req_addr, be_req_mask,
           be_req_wdata, be_res_stall, dram_req_ready, dram_res_valid,
           dram_res_id, dram_res_rdata,
    input  dram_be_stall, dram_be_res_valid, dram_be_res_id, dram_be_res_rdata,
           dram_req_valid, dram_req_write, dram_req_id, dram_req_addr,
           dram_req_mask, dram_req_wdata, dram_res_ready, err_orphan
  );
endinterface

// File: rtl/scpad_dram_arbiter.sv
// Round-robin arbiter from NUM_BE scratchpad backends onto one DRAM port.
// Requests go through a single output register; read sources are kept in
// an in-order tag FIFO so in-order DRAM responses can be steered back.
module scpad_dram_arbiter #(
  parameter int NUM_BE      = 2,
  parameter int ID_W        = 8,
  parameter int ADDR_W      = 32,
  parameter int LANES       = 4,
  parameter int LANE_W      = 16,
  parameter int OUTSTANDING = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  scpad_dram_arbiter_if.master bus
);
  localparam int DATA_W = LANES * LANE_W;
  localparam int BE_W   = (NUM_BE > 1) ? $clog2(NUM_BE) : 1;
  localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(OUTSTANDING) + 1;

  logic              oreg_valid_q, oreg_valid_d;
  logic              oreg_write_q, oreg_write_d;
  logic [ID_W-1:0]   oreg_id_q, oreg_id_d;
  logic [ADDR_W-1:0] oreg_addr_q, oreg_addr_d;
  logic [LANES-1:0]  oreg_mask_q, oreg_mask_d;
  logic [DATA_W-1:0] oreg_wdata_q, oreg_wdata_d;
  logic [BE_W-1:0]   rr_q, rr_d;

  logic [BE_W-1:0]   tag_mem_q [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_BE-1:0]        res_valid_q, res_valid_d;
  logic [NUM_BE*ID_W-1:0]   res_id_q, res_id_d;
  logic [NUM_BE*DATA_W-1:0] res_rdata_q, res_rdata_d;
  logic                     err_q, err_d;

  logic              free, empty, res_ready, pop, push, full_np;
  logic [BE_W-1:0]   head, grant_idx, scan_idx;
  logic              grant_found, grant_valid;
  logic [NUM_BE-1:0] cand, granted;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO that is popping this cycle still has room for a read.
  assign empty     = (cnt_q == '0);
  assign head      = tag_mem_q[rd_ptr_q];
  assign res_ready = empty | ~bus.be_res_stall[head];
  assign pop       = bus.dram_res_valid & res_ready & ~empty;
  assign full_np   = (cnt_q == CNT_W'(OUTSTANDING)) & ~pop;
  assign free      = ~oreg_valid_q | bus.dram_req_ready;
  assign push      = grant_valid & ~bus.be_req_write[grant_idx];

  // Round-robin pick: first eligible backend at or after the pointer.
  always_comb begin
    cand        = bus.be_req_valid & ~(~bus.be_req_write & {NUM_BE{full_np}});
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_BE; k++) begin
      scan_idx = BE_W'((int'(rr_q) + k) % NUM_BE);
      if (!grant_found && cand[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant_valid = grant_found & free;
    granted     = '0;
    if (grant_valid) granted[grant_idx] = 1'b1;
  end

  // Output register load/drain, RR pointer and tag FIFO bookkeeping.
  always_comb begin
    oreg_valid_d = oreg_valid_q;
    oreg_write_d = oreg_write_q;
    oreg_id_d    = oreg_id_q;
    oreg_addr_d  = oreg_addr_q;
    oreg_mask_d  = oreg_mask_q;
    oreg_wdata_d = oreg_wdata_q;
    rr_d         = rr_q;
    if (grant_valid) begin
      oreg_valid_d = 1'b1;
      oreg_write_d = bus.be_req_write[grant_idx];
      oreg_id_d    = bus.be_req_id[grant_idx*ID_W +: ID_W];
      oreg_addr_d  = bus.be_req_addr[grant_idx*ADDR_W +: ADDR_W];
      oreg_mask_d  = bus.be_req_mask[grant_idx*LANES +: LANES];
      oreg_wdata_d = bus.be_req_wdata[grant_idx*DATA_W +: DATA_W];
      rr_d         = (grant_idx == BE_W'(NUM_BE - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.dram_req_ready) begin
      oreg_valid_d = 1'b0;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Response steering: one-cycle pulse to the head backend, payload held.
  always_comb begin
    res_valid_d = '0;
    res_id_d    = res_id_q;
    res_rdata_d = res_rdata_q;
    err_d       = err_q | (bus.dram_res_valid & empty);
    if (pop) begin
      res_valid_d[head]                 = 1'b1;
      res_id_d[head*ID_W +: ID_W]       = bus.dram_res_id;
      res_rdata_d[head*DATA_W +: DATA_W] = bus.dram_res_rdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oreg_valid_q <= 1'b0;
      oreg_write_q <= 1'b0;
      oreg_id_q    <= '0;
      oreg_addr_q  <= '0;
      oreg_mask_q  <= '0;
      oreg_wdata_q <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      res_valid_q  <= '0;
      res_id_q     <= '0;
      res_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      oreg_valid_q <= oreg_valid_d;
      oreg_write_q <= oreg_write_d;
      oreg_id_q    <= oreg_id_d;
      oreg_addr_q  <= oreg_addr_d;
      oreg_mask_q  <= oreg_mask_d;
      oreg_wdata_q <= oreg_wdata_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_rdata_q  <= res_rdata_d;
      err_q        <= err_d;
    end
  end

  // Tag storage; only the pointers need reset.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign bus.dram_be_stall     = rst_i ? '0 : (bus.be_req_valid & ~granted);
  assign bus.dram_req_valid    = oreg_valid_q;
  assign bus.dram_req_write    = oreg_write_q;
  assign bus.dram_req_id       = oreg_id_q;
  assign bus.dram_req_addr     = oreg_addr_q;
  assign bus.dram_req_mask     = oreg_mask_q;
  assign bus.dram_req_wdata    = oreg_wdata_q;
  assign bus.dram_res_ready    = res_ready;
  assign bus.dram_be_res_valid = res_valid_q;
  assign bus.dram_be_res_id    = res_id_q;
  assign bus.dram_be_res_rdata = res_rdata_q;
  assign bus.err_orphan        = err_q;
endmodule

// File: tb/tb_scpad_dram_arbiter.sv
// Directed bench for scpad_dram_arbiter with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_scpad_dram_arbiter;
  localparam int NB = 2, IDW = 8, AW = 32, LN = 4, LW = 16, DW = LN * LW, OUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scpad_dram_arbiter_if #(.NUM_BE(NB), .ID_W(IDW), .ADDR_W(AW), .LANES(LN), .LANE_W(LW)) bus ();

  scpad_dram_arbiter #(.NUM_BE(NB), .ID_W(IDW), .ADDR_W(AW), .LANES(LN), .LANE_W(LW),
                       .OUTSTANDING(OUT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int nvec = 0;
  int nmis = 0;

  // reference model state
  bit          m_ov;
  logic        m_w;
  logic [7:0]  m_id;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [63:0] m_wdata;
  int          mq[$];
  int          m_rr;
  logic [1:0]  m_rv;
  logic [7:0]  m_rid [NB];
  logic [63:0] m_rdata [NB];
  bit          m_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_w = 0; m_id = 0; m_addr = 0; m_mask = 0; m_wdata = 0;
    mq.delete(); m_rr = 0; m_rv = 0; m_err = 0;
    for (int i = 0; i < NB; i++) begin m_rid[i] = 0; m_rdata[i] = 0; end
  endtask

  // compare + model step on every falling edge
  initial begin
    int g, bestd, d, head;
    bit free, empty, popm, fullnp, rrdy;
    logic [NB-1:0] es;
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      empty  = (mq.size() == 0);
      head   = empty ? 0 : mq[0];
      rrdy   = empty || !bus.be_res_stall[head];
      popm   = bus.dram_res_valid && rrdy && !empty;
      fullnp = (mq.size() == OUT) && !popm;
      free   = !m_ov || bus.dram_req_ready;
      g = -1; bestd = NB;
      for (int i = 0; i < NB; i++)
        if (bus.be_req_valid[i] && (bus.be_req_write[i] || !fullnp)) begin
          d = (i - m_rr + NB) % NB;
          if (d < bestd) begin bestd = d; g = i; end
        end
      if (!free || rst) g = -1;
      for (int i = 0; i < NB; i++) es[i] = !rst && bus.be_req_valid[i] && (g != i);

      chk("req_valid", bus.dram_req_valid, m_ov);
      if (m_ov) begin
        chk("req_hdr", {bus.dram_req_write, bus.dram_req_id, bus.dram_req_addr, bus.dram_req_mask},
            {m_w, m_id, m_addr, m_mask});
        chk("req_wdata", bus.dram_req_wdata, m_wdata);
      end
      chk("be_stall", bus.dram_be_stall, es);
      chk("res_ready", bus.dram_res_ready, rrdy);
      chk("res_valid", bus.dram_be_res_valid, m_rv);
      chk("res_id", bus.dram_be_res_id, {m_rid[1], m_rid[0]});
      chk("res_rdata", bus.dram_be_res_rdata, {m_rdata[1], m_rdata[0]});
      chk("err_orphan", bus.err_orphan, m_err);

      if (rst) model_reset();
      else begin
        m_rv = '0;
        if (popm) begin
          m_rv[head] = 1'b1;
          m_rid[head] = bus.dram_res_id;
          m_rdata[head] = bus.dram_res_rdata;
          void'(mq.pop_front());
        end
        if (bus.dram_res_valid && empty) m_err = 1;
        if (g >= 0) begin
          m_ov = 1;
          m_w = bus.be_req_write[g];
          m_id = bus.be_req_id[g*IDW +: IDW];
          m_addr = bus.be_req_addr[g*AW +: AW];
          m_mask = bus.be_req_mask[g*LN +: LN];
          m_wdata = bus.be_req_wdata[g*DW +: DW];
          m_rr = (g + 1) % NB;
          if (!m_w) mq.push_back(g);
        end else if (m_ov && bus.dram_req_ready) m_ov = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.be_req_valid = '0; bus.be_req_write = '0; bus.be_res_stall = '0;
    bus.dram_req_ready = 1'b1; bus.dram_res_valid = 1'b0;
    bus.dram_res_id = '0; bus.dram_res_rdata = '0;
  endtask

  task automatic set_req(input int b, input logic w, input logic [7:0] id, input logic [31:0] a);
    bus.be_req_write[b] = w;
    bus.be_req_id[b*IDW +: IDW] = id;
    bus.be_req_addr[b*AW +: AW] = a;
    bus.be_req_mask[b*LN +: LN] = id[3:0] | 4'h1;
    bus.be_req_wdata[b*DW +: DW] = {a, ~a};
  endtask

  // return every outstanding read, bounded
  task automatic drain();
    int k;
    k = 0;
    bus.be_res_stall = '0;
    while (mq.size() > 0 && k < 40) begin
      bus.dram_res_valid = 1'b1;
      bus.dram_res_id = 8'hE0 + 8'(k);
      bus.dram_res_rdata = {32'hD0D0_0000, 32'(k)};
      cyc();
      k++;
    end
    bus.dram_res_valid = 1'b0;
    if (mq.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout: %0d reads still outstanding, want 0", mq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.be_req_id = '0; bus.be_req_addr = '0; bus.be_req_mask = '0; bus.be_req_wdata = '0;
    // T1: reset with everything active
    bus.be_req_valid = '1; bus.be_req_write = '1; bus.be_res_stall = '1;
    bus.dram_req_ready = 1'b1; bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'hFF; bus.dram_res_rdata = '1;
    cyc(); cyc();
    @(negedge clk);
    chk("t1_req_valid", bus.dram_req_valid, 1'b0);
    chk("t1_stall", bus.dram_be_stall, 2'b00);
    chk("t1_res_valid", bus.dram_be_res_valid, 2'b00);
    chk("t1_res_ready", bus.dram_res_ready, 1'b1);
    chk("t1_err", bus.err_orphan, 1'b0);
    cyc();
    rst = 1'b0;
    idle_inputs();

    // T2: both backends read continuously
    set_req(0, 1'b0, 8'h01, 32'h100);
    set_req(1, 1'b0, 8'h02, 32'h200);
    bus.be_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_stall", bus.dram_be_stall, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) chk("t2_req_id", bus.dram_req_id, (k % 2 == 1) ? 8'h01 : 8'h02);
      cyc();
    end
    bus.be_req_valid = 2'b00;
    @(negedge clk);
    chk("t2_last_id", bus.dram_req_id, 8'h02);
    cyc();
    drain();

    // T3: DRAM back-pressure holds the output register
    bus.dram_req_ready = 1'b0;
    set_req(0, 1'b0, 8'h03, 32'h100);
    bus.be_req_valid = 2'b01;
    @(negedge clk);
    chk("t3_first_grant", bus.dram_be_stall, 2'b00);
    cyc();
    set_req(1, 1'b0, 8'h04, 32'h200);
    bus.be_req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.dram_req_valid, 1'b1);
      chk("t3_hold_addr", bus.dram_req_addr, 32'h100);
      chk("t3_hold_stall", bus.dram_be_stall, 2'b11);
      cyc();
    end
    bus.dram_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_stall", bus.dram_be_stall, 2'b01);
    cyc();
    bus.be_req_valid = 2'b01;
    @(negedge clk);
    chk("t3_next_addr", bus.dram_req_addr, 32'h200);
    cyc();
    bus.be_req_valid = 2'b00;
    cyc();
    drain();

    // T4: tag FIFO full blocks the ninth read until a pop
    bus.be_req_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b0, 8'h40 + 8'(k), 32'h1000 + 32'(k * 4));
      cyc();
    end
    set_req(0, 1'b0, 8'h48, 32'h2000);
    @(negedge clk);
    chk("t4_full_stall", bus.dram_be_stall, 2'b01);
    cyc();
    @(negedge clk);
    chk("t4_full_stall2", bus.dram_be_stall, 2'b01);
    cyc();
    bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'h77;
    bus.dram_res_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("t4_pop_grant", bus.dram_be_stall, 2'b00);
    chk("t4_pop_ready", bus.dram_res_ready, 1'b1);
    cyc();
    bus.dram_res_valid = 1'b0;
    bus.be_req_valid = 2'b00;
    @(negedge clk);
    chk("t4_res_valid", bus.dram_be_res_valid, 2'b01);
    chk("t4_res_rdata", bus.dram_be_res_rdata[DW-1:0], 64'h0123_4567_89AB_CDEF);
    chk("t4_req_id", bus.dram_req_id, 8'h48);
    cyc();
    drain();

    // T5: responses return to their issuing backend in order
    set_req(1, 1'b0, 8'h08, 32'h300);
    bus.be_req_valid = 2'b10;
    cyc();
    set_req(0, 1'b0, 8'h10, 32'h400);
    bus.be_req_valid = 2'b01;
    cyc();
    bus.be_req_valid = 2'b00;
    bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'h08;
    bus.dram_res_rdata = 64'hAAAA_1111_AAAA_2222;
    cyc();
    bus.dram_res_id = 8'h10;
    bus.dram_res_rdata = 64'hBBBB_3333_BBBB_4444;
    @(negedge clk);
    chk("t5_a_valid", bus.dram_be_res_valid, 2'b10);
    chk("t5_a_id", bus.dram_be_res_id[IDW +: IDW], 8'h08);
    chk("t5_a_rdata", bus.dram_be_res_rdata[DW +: DW], 64'hAAAA_1111_AAAA_2222);
    cyc();
    bus.dram_res_valid = 1'b0;
    @(negedge clk);
    chk("t5_b_valid", bus.dram_be_res_valid, 2'b01);
    chk("t5_b_id", bus.dram_be_res_id[0 +: IDW], 8'h10);
    chk("t5_b_rdata", bus.dram_be_res_rdata[0 +: DW], 64'hBBBB_3333_BBBB_4444);
    chk("t5_a_id_held", bus.dram_be_res_id[IDW +: IDW], 8'h08);
    cyc();

    // T6: head backend stalls the response, then an orphan arrives
    set_req(1, 1'b0, 8'h20, 32'h500);
    bus.be_req_valid = 2'b10;
    cyc();
    bus.be_req_valid = 2'b00;
    bus.be_res_stall = 2'b10;
    bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'h20;
    bus.dram_res_rdata = 64'hCCCC_5555_CCCC_6666;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_ready_low", bus.dram_res_ready, 1'b0);
      chk("t6_no_res", bus.dram_be_res_valid, 2'b00);
      cyc();
    end
    bus.be_res_stall = 2'b00;
    @(negedge clk);
    chk("t6_ready_high", bus.dram_res_ready, 1'b1);
    cyc();
    @(negedge clk);
    chk("t6_res_valid", bus.dram_be_res_valid, 2'b10);
    chk("t6_res_id", bus.dram_be_res_id[IDW +: IDW], 8'h20);
    chk("t6_err_before", bus.err_orphan, 1'b0);
    cyc();
    bus.dram_res_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_set", bus.err_orphan, 1'b1);
    cyc();
    @(negedge clk);
    chk("t6_err_sticky", bus.err_orphan, 1'b1);
    cyc();

    // T7: a write takes no FIFO slot, so the next response goes to BE1
    set_req(0, 1'b1, 8'h50, 32'h600);
    bus.be_req_valid = 2'b01;
    cyc();
    set_req(1, 1'b0, 8'h51, 32'h700);
    bus.be_req_valid = 2'b10;
    @(negedge clk);
    chk("t7_write", {bus.dram_req_write, bus.dram_req_id}, {1'b1, 8'h50});
    cyc();
    bus.be_req_valid = 2'b00;
    bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'h51;
    bus.dram_res_rdata = 64'hDDDD_7777_DDDD_8888;
    cyc();
    bus.dram_res_valid = 1'b0;
    @(negedge clk);
    chk("t7_res_valid", bus.dram_be_res_valid, 2'b10);
    chk("t7_res_rdata", bus.dram_be_res_rdata[DW +: DW], 64'hDDDD_7777_DDDD_8888);
    cyc();

    // T8: reset mid-flight, late response becomes an orphan
    set_req(0, 1'b0, 8'h30, 32'h800);
    bus.be_req_valid = 2'b01;
    cyc();
    bus.be_req_valid = 2'b00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.dram_res_valid = 1'b1;
    bus.dram_res_id = 8'h30;
    @(negedge clk);
    chk("t8_err_cleared", bus.err_orphan, 1'b0);
    chk("t8_oreg_cleared", bus.dram_req_valid, 1'b0);
    chk("t8_res_ready", bus.dram_res_ready, 1'b1);
    cyc();
    bus.dram_res_valid = 1'b0;
    @(negedge clk);
    chk("t8_orphan", bus.err_orphan, 1'b1);
    chk("t8_no_res", bus.dram_be_res_valid, 2'b00);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
